// File: rtl/nic_pkg.sv
// Shared constants for the PE network interface: register map, flit width, VC bit.
// No logic; constants only.
// Not applicable (no handshake).
package nic_pkg;

    localparam int FLIT_W = 64;
    localparam int VC_BIT = 63;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_channel_buf.sv
// One-entry flit buffer with full flag, load and clear strobes.
// Load and clear take effect on the next rising edge.
// No internal backpressure: the owner only loads when empty; load wins over clear.
module nic_channel_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         full
);

    logic [W-1:0] data_q, data_d;
    logic         full_q, full_d;

    // Next-state: capture on load, otherwise drop the full flag on clear.
    // Clearing leaves the data in place so a later read returns the stale flit.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (ld) begin
            data_d = d;
            full_d = 1'b1;
        end else if (clr) begin
            full_d = 1'b0;
        end
    end

    // State register; reset empties the buffer and zeroes the data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign q    = data_q;
    assign full = full_q;

endmodule

// File: rtl/pe_nic.sv
// PE-to-router network interface: 4-register PE map plus one-flit in/out channel buffers.
// PE reads return one cycle later; a flit is offered to the router the cycle after it is written.
// Writes to a full output buffer are dropped; net_ri deasserts while the input buffer is full.
module pe_nic
    import nic_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_W,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    input  logic                  net_polarity
);

    logic [DATA_WIDTH-1:0] in_buf, out_buf;
    logic                  in_full, out_full;
    logic                  pe_rd, pe_wr;
    logic                  out_ld, in_ld, in_clr;
    logic [DATA_WIDTH-1:0] d_out_q, d_out_d;

    assign pe_rd = nicEn & ~nicWrEn;
    assign pe_wr = nicEn & nicWrEn;

    // The VC bit is the flit MSB; only inject into the VC the router is not forwarding.
    assign net_so = out_full & net_ro & (out_buf[DATA_WIDTH-1] != net_polarity);
    assign net_do = out_buf;
    assign net_ri = ~in_full;

    // Load and clear of each buffer are mutually exclusive by construction:
    // loads require the pre-edge empty state, clears require the pre-edge full state.
    assign out_ld = pe_wr & (addr == ADDR_OUT_BUF) & ~out_full;
    assign in_ld  = net_si & ~in_full;
    assign in_clr = pe_rd & (addr == ADDR_IN_BUF) & in_full;

    nic_channel_buf #(.W(DATA_WIDTH)) u_out_buf (
        .clk   (clk),
        .reset (reset),
        .ld    (out_ld),
        .clr   (net_so),
        .d     (d_in),
        .q     (out_buf),
        .full  (out_full)
    );

    nic_channel_buf #(.W(DATA_WIDTH)) u_in_buf (
        .clk   (clk),
        .reset (reset),
        .ld    (in_ld),
        .clr   (in_clr),
        .d     (net_di),
        .q     (in_buf),
        .full  (in_full)
    );

    // Read mux: d_out holds unless a read is issued; the write-only buffer reads as zero.
    always_comb begin
        d_out_d = d_out_q;
        if (pe_rd) begin
            case (addr)
                ADDR_IN_BUF:   d_out_d = in_buf;
                ADDR_IN_STAT:  d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_BUF:  d_out_d = '0;
                ADDR_OUT_STAT: d_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:       d_out_d = '0;
            endcase
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out_q <= '0;
        end else begin
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;

endmodule

// File: tb/tb_pe_nic.sv
module tb_pe_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_polarity;

    int total;
    int bad;
    int n_sent;

    logic [63:0] sent_q[$];
    logic [63:0] rd_q[$];

    pe_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_polarity (net_polarity)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle: at the falling edge score any send against the expected-flit queue,
    // then advance past the next rising edge.
    task automatic tick();
        logic [63:0] exp;
        @(negedge clk);
        if (net_so === 1'b1) begin
            n_sent++;
            total++;
            if (sent_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_send: net_so=1 net_do=%h, required no send", net_do);
            end else begin
                exp = sent_q.pop_front();
                if (net_do !== exp) begin
                    bad++;
                    $display("FAIL send_data: net_do=%h required=%h", net_do, exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pe_write(input logic [1:0] a, input logic [63:0] v);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic pe_read(input logic [1:0] a, input logic [63:0] exp, input string name);
        logic [63:0] e;
        rd_q.push_back(exp);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        tick();
        nicEn = 1'b0;
        e = rd_q.pop_front();
        total++;
        if (d_out !== e) begin
            bad++;
            $display("FAIL %s: d_out=%h required=%h", name, d_out, e);
        end
    endtask

    task automatic check_bit(input logic obs, input logic exp, input string name);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%b required=%b", name, obs, exp);
        end
    endtask

    task automatic check_sent(input int exp, input string name);
        total++;
        if (n_sent !== exp) begin
            bad++;
            $display("FAIL %s: sends=%0d required=%0d", name, n_sent, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; net_si = 1'b1; net_ro = 1'b1; net_di = 64'hFFFF;
        repeat (3) tick();
        check_bit(net_so, 1'b0, "reset_net_so");
        check_bit(net_ri, 1'b1, "reset_net_ri");
        total++;
        if (d_out !== 64'd0 || net_do !== 64'd0) begin
            bad++;
            $display("FAIL reset_data: d_out=%h net_do=%h required=0", d_out, net_do);
        end
        net_si = 1'b0;
        reset = 1'b1;
        tick();
        pe_read(2'b01, 64'd0, "reset_in_stat");
        pe_read(2'b11, 64'd0, "reset_out_stat");
        pe_read(2'b00, 64'd0, "reset_in_buf");
    endtask

    task automatic test_inject();
        int n0;
        net_polarity = 1'b1; net_ro = 1'b1;
        n0 = n_sent;
        sent_q.push_back(64'h0000_0000_DEAD_BEEF);
        pe_write(2'b10, 64'h0000_0000_DEAD_BEEF);
        check_bit(net_so, 1'b1, "inject_so_pulse");
        tick();
        check_bit(net_so, 1'b0, "inject_so_end");
        check_sent(n0 + 1, "inject_count");
        pe_read(2'b11, 64'd0, "inject_out_stat");
        pe_read(2'b10, 64'd0, "read_wo_reg");
    endtask

    task automatic test_polarity();
        int n0;
        net_polarity = 1'b1; net_ro = 1'b1;
        n0 = n_sent;
        sent_q.push_back(64'h8000_0000_0000_0001);
        pe_write(2'b10, 64'h8000_0000_0000_0001);
        repeat (3) tick();
        check_bit(net_so, 1'b0, "polarity_blocked");
        check_sent(n0, "polarity_no_send");
        pe_read(2'b11, 64'd1, "polarity_out_full");
        net_polarity = 1'b0;
        repeat (4) tick();
        check_sent(n0 + 1, "polarity_one_send");
        pe_read(2'b11, 64'd0, "polarity_out_empty");
    endtask

    task automatic test_drop_when_full();
        int n0;
        net_polarity = 1'b1; net_ro = 1'b0;
        n0 = n_sent;
        sent_q.push_back(64'h0000_0000_0000_0111);
        pe_write(2'b10, 64'h0000_0000_0000_0111);
        pe_write(2'b10, 64'h0000_0000_0000_0222);
        tick();
        check_sent(n0, "drop_held");
        total++;
        if (net_do !== 64'h111) begin
            bad++;
            $display("FAIL drop_retained: net_do=%h required=%h", net_do, 64'h111);
        end
        pe_read(2'b11, 64'd1, "drop_out_full");
        net_ro = 1'b1;
        repeat (4) tick();
        check_sent(n0 + 1, "drop_only_first");
        // Write on the same edge as a send: full check uses the pre-edge flag.
        sent_q.push_back(64'h0000_0000_0000_0333);
        pe_write(2'b10, 64'h0000_0000_0000_0333);
        pe_write(2'b10, 64'h0000_0000_0000_0444);
        repeat (3) tick();
        check_sent(n0 + 2, "send_write_collide");
        pe_read(2'b11, 64'd0, "collide_out_empty");
        // Writes to read-only addresses do nothing.
        pe_write(2'b11, 64'h1);
        pe_write(2'b01, 64'h1);
        pe_read(2'b11, 64'd0, "ro_write_out_stat");
        pe_read(2'b01, 64'd0, "ro_write_in_stat");
    endtask

    task automatic test_eject();
        net_di = 64'h1234; net_si = 1'b1;
        tick();
        net_si = 1'b0;
        check_bit(net_ri, 1'b0, "eject_ri_low");
        pe_read(2'b01, 64'd1, "eject_in_stat");
        pe_read(2'b00, 64'h1234, "eject_data");
        check_bit(net_ri, 1'b1, "eject_ri_high");
        pe_read(2'b01, 64'd0, "eject_in_stat_clr");
        pe_read(2'b00, 64'h1234, "eject_stale");
        // Arrival and read of the empty input buffer on the same edge.
        net_di = 64'h5678; net_si = 1'b1;
        pe_read(2'b00, 64'h1234, "arrive_read_old");
        net_si = 1'b0;
        check_bit(net_ri, 1'b0, "arrive_read_full");
        // Send while full must not overwrite.
        net_di = 64'hAAAA; net_si = 1'b1;
        tick();
        net_si = 1'b0;
        pe_read(2'b00, 64'h5678, "eject_no_overwrite");
        check_bit(net_ri, 1'b1, "eject_ri_after");
    endtask

    task automatic test_reset_mid();
        int n0;
        net_ro = 1'b0; net_polarity = 1'b1;
        n0 = n_sent;
        pe_write(2'b10, 64'h0000_0000_0000_0BAD);
        net_di = 64'h0000_0000_0000_0C0D; net_si = 1'b1;
        tick();
        net_si = 1'b0;
        check_bit(net_ri, 1'b0, "mid_in_full");
        pe_read(2'b11, 64'd1, "mid_out_full");
        #2;
        reset = 1'b0;
        #1;
        check_bit(net_ri, 1'b1, "mid_async_ri");
        check_bit(net_so, 1'b0, "mid_async_so");
        total++;
        if (d_out !== 64'd0 || net_do !== 64'd0) begin
            bad++;
            $display("FAIL mid_async_data: d_out=%h net_do=%h required=0", d_out, net_do);
        end
        net_ro = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        check_sent(n0, "mid_no_send");
        pe_read(2'b01, 64'd0, "mid_post_in_stat");
        pe_read(2'b11, 64'd0, "mid_post_out_stat");
        pe_read(2'b00, 64'd0, "mid_post_in_buf");
    endtask

    initial begin
        total = 0; bad = 0; n_sent = 0;
        reset = 1'b0; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_ro = 1'b0; net_si = 1'b0; net_di = '0; net_polarity = 1'b0;
        test_reset();
        test_inject();
        test_polarity();
        test_drop_when_full();
        test_eject();
        test_reset_mid();
        total++;
        if (sent_q.size() != 0) begin
            bad++;
            $display("FAIL sends_outstanding: left=%0d required=0", sent_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
